// File: rtl/sysarr_out_buf.sv
// Ping-pong output buffer for a systolic array.
// Rows are written into one bank while the other bank drains a completed
// tile to the consumer. Each bank is marked full when its last row lands,
// and it is released once its last row has been accepted downstream.
module sysarr_out_buf #(
    parameter int DW   = 16,
    parameter int N    = 4,
    parameter int ROWS = 4
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    flush,
    input  logic                    shift,
    input  logic [DW*N-1:0]         shift_value,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW*N-1:0]         out_data,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic                    out_last,
    output logic [1:0]              occupancy,
    output logic                    overflow
);

    localparam int W  = DW * N;
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [W-1:0]  mem_q [2][ROWS];
    logic [W-1:0]  mem_d [2][ROWS];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          wr_fire;
    logic          rd_fire;

    // Handshake status comes from registered state only, so a drain that
    // frees a bank cannot let a write into it in the same cycle.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem_q[rd_bank_q][rd_row_q];
    assign out_row   = rd_row_q;
    assign out_last  = out_valid && (rd_row_q == LAST_ROW);
    assign occupancy = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign overflow  = overflow_q;

    assign wr_fire = shift && in_ready;
    assign rd_fire = out_valid && out_ready;

    // Next-state: pointer advance, bank hand-over, sticky overflow, flush.
    always_comb begin
        mem_d      = mem_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_row_d   = wr_row_q;
        rd_row_d   = rd_row_q;
        full_d     = full_q;
        overflow_d = overflow_q;

        if (flush) begin
            // Storage is deliberately left alone; only control state clears.
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_row_d   = '0;
            rd_row_d   = '0;
            full_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (shift && !in_ready) begin
                overflow_d = 1'b1;
            end

            if (wr_fire) begin
                mem_d[wr_bank_q][wr_row_q] = shift_value;
                if (wr_row_q == LAST_ROW) begin
                    wr_row_d          = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end

            // Write and drain never touch the same bank in one cycle: a write
            // needs its bank empty, a drain needs its bank full.
            if (rd_fire) begin
                if (rd_row_q == LAST_ROW) begin
                    rd_row_d          = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    rd_row_d = rd_row_q + 1'b1;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            full_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank storage; cleared by reset so out_data reads zero afterwards.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
